eth_tx_sched: RTL and testbench
===============================

// Module: eth_tx_sched
// PURPOSE
//  Parametrised TX scheduler between the RX parser and N reply/stream TX engines (ARP, PING, UDP, ...).
//  Latches per-channel request pulses, grants one idle engine at a time (fixed-priority or round-robin).
//  Issues a one-cycle start strobe and holds the grant until that engine's ready rises again.
//  A watchdog aborts a grant whose engine never completes.
// PARAMETERS
//  N_CH       4      number of TX channels (2..16); channel 0 = highest fixed priority
//  RR_MODE    0      0 = fixed priority (lowest index wins), 1 = round-robin
//  TIMEOUT    65535  cycles in ACTIVE before abort; 0 disables watchdog
//  CNT_W      16     watchdog counter width; TIMEOUT must fit in CNT_W bits
//  CH_W       4      width of channel index, >= clog2(N_CH)
// PORTS
//  clk           in   1      system clock
//  rst_n         in   1      reset, synchronous, active-low
//  i_req         in   N_CH   request pulses (ARP/PING flag set, UDP sync, ...); one bit per channel
//  i_ch_en       in   N_CH   channel enable mask; disabled channel is never granted, its pending kept
//  i_ready       in   N_CH   engine idle/ready level; engine drops it while sending, raises when done
//  o_pend        out  N_CH   latched pending requests
//  o_start       out  N_CH   one-hot, one-cycle start strobe to the granted engine (also clears parser flag)
//  o_active      out  1      a grant is held
//  o_active_idx  out  CH_W   index of granted channel (0 when idle)
//  o_done        out  1      one-cycle pulse: granted engine completed
//  o_timeout     out  1      one-cycle pulse: grant aborted by watchdog
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state IDLE; o_pend=0, o_start=0, o_active=0, o_active_idx=0,
//   o_done=0, o_timeout=0, RR pointer=0, watchdog=0, ready history=all ones. Reset mid-grant drops it.
//  Pending: pend[c] <= (pend[c] & ~clr[c]) | i_req[c]; clr[c] = start issued for c this cycle.
//   Simultaneous set and clear: set wins (new request survives, served again later).
//  Eligible: elig = o_pend & i_ch_en & i_ready (all registered/level inputs, no comb path to i_req).
//  Select: RR_MODE=0 -> lowest set index of elig. RR_MODE=1 -> first set index at or after RR pointer,
//   wrapping N_CH-1 -> 0; pointer <= granted idx+1 (mod N_CH) on each grant.
//  FSM:
//   IDLE   : elig != 0 -> START, latch idx; else stay.
//   START  : o_start[idx]=1 for exactly this cycle, pend[idx] cleared, watchdog<=0 -> ACTIVE.
//   ACTIVE : done = i_ready[idx] & ~ready_q[idx] (rising edge, ready_q = i_ready delayed 1 clk).
//            done -> o_done pulse, IDLE. Else if TIMEOUT!=0 and watchdog==TIMEOUT-1 -> o_timeout pulse, IDLE
//            (done wins if both in same cycle). Else watchdog+1 (saturating).
//  o_active=1 in START and ACTIVE; o_active_idx valid in START/ACTIVE.
//  Latency: i_req pulse at edge t -> pend at t+1 -> START (o_start high) cycle t+2 if eligible.
//  Back-to-back: after o_done, IDLE for one cycle minimum before next START.
//  Engine whose ready never drops: rising edge cannot occur; only watchdog ends the grant.
//  Requests on the active channel during ACTIVE latch into pend and are served after return to IDLE.
//  i_ch_en deasserted during ACTIVE does not abort the current grant.
// TESTING
//  1 Fixed prio: i_req=4'b0110 one pulse, all ready/en -> o_start=0010 at t+2; after ch1 ready rise,
//    o_done, then o_start=0100; o_pend returns 0000.
//  2 RR_MODE=1: keep i_req=4'b1111 each cycle, engines complete in 3 cycles -> grant order 0,1,2,3,0,...
//  3 Watchdog: TIMEOUT=8, ch2 drops ready and never raises -> o_timeout exactly 8 cycles after ACTIVE
//    entry, o_active=0 next, o_done never pulses.
//  4 Set/clear collision: i_req[0] pulse in START cycle of ch0 -> o_pend[0]=1 after, ch0 granted again.
//  5 Mask/not-ready: i_ch_en[0]=0 with pend=0001 -> no start, pend held; enable -> o_start=0001 next+1.
//  6 Reset in ACTIVE: rst_n low one edge -> all outputs 0, o_pend 0, no o_done on later ready rise.

Source files
------------

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: latches per-channel TX requests, grants one idle engine at a time and
// holds the grant until the engine's ready rises again or the watchdog aborts it.
module eth_tx_sched #(
   parameter int N_CH    = 4,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 65535,
   parameter int CNT_W   = 16,
   parameter int CH_W    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] i_req,
   input  logic [N_CH-1:0] i_ch_en,
   input  logic [N_CH-1:0] i_ready,
   output logic [N_CH-1:0] o_pend,
   output logic [N_CH-1:0] o_start,
   output logic            o_active,
   output logic [CH_W-1:0] o_active_idx,
   output logic            o_done,
   output logic            o_timeout
);
   typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
   state_t          state_q;
   logic [N_CH-1:0] pend_q, pend_d, ready_q, start_q, elig, sh, rise_sh;
   logic [CH_W-1:0] ptr_q, idx_q, sel;
   logic [CNT_W-1:0] wd_q;
   logic            found, done, wd_fire, done_q, to_q;
   int              c;
   // Scan starts at the RR pointer in round-robin mode, at channel 0 otherwise.
   always_comb begin
      elig = pend_q & i_ch_en & i_ready;
      sel = '0;
      found = 1'b0;
      c = 0;
      sh = '0;
      for (int k = 0; k < N_CH; k++) begin
         c = (RR_MODE != 0) ? (int'(ptr_q) + k) % N_CH : k;
         sh = elig >> c;
         if (!found && sh[0]) begin
            found = 1'b1;
            sel = CH_W'(c);
         end
      end
   end
   // start_q is only non-zero during START, so it doubles as the pending clear; set wins.
   assign pend_d  = (pend_q & ~start_q) | i_req;
   assign rise_sh = (i_ready & ~ready_q) >> idx_q;
   assign done    = rise_sh[0];
   assign wd_fire = (TIMEOUT != 0) && (wd_q == WD_LAST);
   assign o_pend       = pend_q;
   assign o_start      = start_q;
   assign o_active     = state_q != IDLE;
   assign o_active_idx = idx_q;
   assign o_done       = done_q;
   assign o_timeout    = to_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ready_q <= '1;
         start_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         ready_q <= i_ready;
         start_q <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
         case (state_q)
            IDLE: if (found) begin
               state_q <= START;
               idx_q   <= sel;
               start_q <= N_CH'(1) << sel;
               ptr_q   <= (int'(sel) == N_CH - 1) ? '0 : sel + 1'b1;
            end
            START: begin
               state_q <= ACTIVE;
               wd_q    <= '0;
            end
            default: if (done) begin
               state_q <= IDLE;
               idx_q   <= '0;
               done_q  <= 1'b1;
            end else if (wd_fire) begin
               state_q <= IDLE;
               idx_q   <= '0;
               to_q    <= 1'b1;
            end else if (wd_q != '1) begin
               wd_q <= wd_q + 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed vector table plus hand-written watchdog, reset and round-robin sequences.
module tb_eth_tx_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req, en, rdy;
   logic [3:0] f_pend, f_start, f_idx, r_pend, r_start, r_idx;
   logic       f_act, f_done, f_to, r_act, r_done, r_to;
   int         total = 0;
   int         bad = 0;
   int         cnt [4];
   int         grants, gidx;
   int         exp_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   typedef struct {
      logic [3:0] req, en, rdy, start, pend;
      logic       act, done;
      logic [3:0] idx;
   } vec_t;
   vec_t v [20];

   always #5 clk = ~clk;

   eth_tx_sched #(.N_CH(4), .RR_MODE(0), .TIMEOUT(8), .CNT_W(16), .CH_W(4)) dut_fp (
      .clk(clk), .rst_n(rst_n), .i_req(req), .i_ch_en(en), .i_ready(rdy),
      .o_pend(f_pend), .o_start(f_start), .o_active(f_act), .o_active_idx(f_idx),
      .o_done(f_done), .o_timeout(f_to));

   eth_tx_sched #(.N_CH(4), .RR_MODE(1), .TIMEOUT(0), .CNT_W(16), .CH_W(4)) dut_rr (
      .clk(clk), .rst_n(rst_n), .i_req(req), .i_ch_en(en), .i_ready(rdy),
      .o_pend(r_pend), .o_start(r_start), .o_active(r_act), .o_active_idx(r_idx),
      .o_done(r_done), .o_timeout(r_to));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req = '0;
      en  = 4'b1111;
      rdy = 4'b1111;
      // {req, en, rdy, exp start, exp pend, exp active, exp done, exp idx}
      v[0]  = '{4'b0110, 4'b1111, 4'b1111, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'd0};
      v[1]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0010, 4'b0110, 1'b1, 1'b0, 4'd1};
      v[2]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 4'd1};
      v[3]  = '{4'b0000, 4'b1111, 4'b1101, 4'b0000, 4'b0100, 1'b1, 1'b0, 4'd1};
      v[4]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'd0};
      v[5]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0100, 4'b0100, 1'b1, 1'b0, 4'd2};
      v[6]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd2};
      v[7]  = '{4'b0000, 4'b1111, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd2};
      v[8]  = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0};
      v[9]  = '{4'b0001, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'd0};
      v[10] = '{4'b0000, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'd0};
      v[11] = '{4'b0000, 4'b1111, 4'b1110, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'd0};
      v[12] = '{4'b0000, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'd0};
      v[13] = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 4'd0};
      v[14] = '{4'b0000, 4'b1110, 4'b1110, 4'b0000, 4'b0001, 1'b1, 1'b0, 4'd0};
      v[15] = '{4'b0000, 4'b1110, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'd0};
      v[16] = '{4'b0000, 4'b1111, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'd0};
      v[17] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0};
      v[18] = '{4'b0000, 4'b1111, 4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'd0};
      v[19] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0};

      tick();
      tick();
      chk("rst_pend", 32'(f_pend), 32'd0);
      chk("rst_start", 32'(f_start), 32'd0);
      chk("rst_active", 32'(f_act), 32'd0);
      chk("rst_idx", 32'(f_idx), 32'd0);
      chk("rst_done_to", 32'({f_done, f_to}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         req = v[i].req;
         en  = v[i].en;
         rdy = v[i].rdy;
         tick();
         chk($sformatf("vec%0d_start", i), 32'(f_start), 32'(v[i].start));
         chk($sformatf("vec%0d_pend", i), 32'(f_pend), 32'(v[i].pend));
         chk($sformatf("vec%0d_active", i), 32'(f_act), 32'(v[i].act));
         chk($sformatf("vec%0d_done", i), 32'(f_done), 32'(v[i].done));
         chk($sformatf("vec%0d_idx", i), 32'(f_idx), 32'(v[i].idx));
      end

      req = 4'b0100;
      tick();
      req = '0;
      for (int n = 0; n < 6 && f_start == '0; n++) tick();
      chk("wd_start", 32'(f_start), 32'b0100);
      rdy = 4'b1011;
      for (int n = 1; n <= 9; n++) begin
         tick();
         chk($sformatf("wd_to_%0d", n), 32'(f_to), 32'(n == 9));
         chk($sformatf("wd_active_%0d", n), 32'(f_act), 32'(n != 9));
         chk($sformatf("wd_done_%0d", n), 32'(f_done), 32'd0);
      end
      tick();
      chk("wd_to_pulse_end", 32'(f_to), 32'd0);
      rdy = 4'b1111;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("wd_no_late_done", 32'(f_done), 32'd0);
      end
      chk("wd_pend_clear", 32'(f_pend), 32'd0);

      req = 4'b0010;
      tick();
      req = '0;
      for (int n = 0; n < 6 && f_start == '0; n++) tick();
      chk("rstact_start", 32'(f_start), 32'b0010);
      rdy = 4'b1101;
      req = 4'b1000;
      tick();
      req = '0;
      tick();
      chk("rstact_active", 32'(f_act), 32'd1);
      chk("rstact_pend", 32'(f_pend), 32'b1000);
      rst_n = 1'b0;
      tick();
      chk("rstact_active0", 32'(f_act), 32'd0);
      chk("rstact_idx0", 32'(f_idx), 32'd0);
      chk("rstact_pend0", 32'(f_pend), 32'd0);
      chk("rstact_start0", 32'(f_start), 32'd0);
      rst_n = 1'b1;
      rdy = 4'b1111;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("rstact_no_done", 32'(f_done), 32'd0);
         chk("rstact_idle", 32'(f_act), 32'd0);
      end

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req = 4'b1111;
      grants = 0;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int n = 0; n < 200 && grants < 8; n++) begin
         tick();
         if (r_start != '0) begin
            gidx = -1;
            for (int c = 0; c < 4; c++) if (r_start[c]) gidx = c;
            chk($sformatf("rr_onehot_%0d", grants), 32'($countones(r_start)), 32'd1);
            chk($sformatf("rr_order_%0d", grants), 32'(gidx), 32'(exp_ord[grants]));
            chk($sformatf("rr_idx_%0d", grants), 32'(r_idx), 32'(exp_ord[grants]));
            if (gidx >= 0) cnt[gidx] = 3;
            grants++;
         end
         for (int c = 0; c < 4; c++) begin
            rdy[c] = (cnt[c] == 0);
            if (cnt[c] > 0) cnt[c]--;
         end
      end
      chk("rr_grant_count", 32'(grants), 32'd8);
      req = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
